multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Sequencing controller for the multicycle RV32I core variant. The datapath shares one ALU and one unified instruction/data memory port. The block walks each instruction through fetch/decode/execute/memory/writeback states and drives datapath selects and write enables per state. It waits on a memory ready handshake, watchdogs that handshake, traps unsupported encodings and counts retired instructions.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles with mem_ready low in a wait state before HALT (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
Op  in  7  instruction opcode from instruction register
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction/OldPC register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (combinational from Op)
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  one-cycle pulse in TRAP
halted  out  1  high in HALT
retire  out  1  one-cycle pulse when an instruction completes
instret  out  CNT_W  retired-instruction count

Behaviour:
- Moore outputs decode from registered state. All unlisted enables are 0. Selects default to 00 / AdrSrc 0.
- While rst low: state=FETCH, wait_cnt=0, instret=0. All enables, retire, illegal_instr and halted are forced 0.
- FETCH: ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay until mem_ready=1, then DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target into ALUOut). Next state by Op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - else -> TRAP
  - funct3 not in {000,010,110,111} for 0110011/0010011 -> TRAP
  - 1100011 with funct3≠000 -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1. Wait for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. Then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode. Next ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct decode. Next ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Next FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next ALUWB (rd=OldPC+4).
- TRAP: illegal_instr=1, no writes. Next FETCH. PC was already advanced, so the bad instruction is skipped.
- HALT: halted=1, all enables 0. Absorbing until reset.
- Funct decode:
  - funct3 000: sub iff Op=0110011 and funct7[5]=1, else add
  - funct3 010: slt
  - funct3 110: or
  - funct3 111: and
- Watchdog (FETCH, MEMREAD, MEMWRITE):
  - wait_cnt clears on entry.
  - Increments each cycle mem_ready=0.
  - If mem_ready=0 and wait_cnt==MEM_WAIT_MAX-1, next state is HALT, i.e. after MEM_WAIT_MAX consecutive low cycles.
  - mem_ready=1 on the limit cycle wins and proceeds normally.
- retire pulses on exit from MEMWB, MEMWRITE (on mem_ready), ALUWB and BEQ. instret increments on the same edge and wraps modulo 2^CNT_W. TRAP does not retire.
- Async reset mid-instruction: immediate return to FETCH with no write strobes; instret cleared.

Test Plan:
- add x3,x1,x2 (Op 0110011, f3 000, f7 0): mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB. ALUControl=000 in EXECR, RegWrite=1 in ALUWB, retire at cycle 4, instret=1.
- sub (f7 0100000) -> EXECR ALUControl=001. addi with f7 bits set -> ALUControl=000.
- lw with mem_ready low 3 cycles in MEMREAD: 8 cycles total. AdrSrc=1 throughout MEMREAD, ResultSrc=01 + RegWrite in MEMWB. sw: MemWrite held 4 cycles, single retire.
- beq with Zero=1 -> PCWrite=1 in BEQ. Zero=0 -> PCWrite=0. Both retire.
- Op 1111111 -> DECODE, TRAP, illegal_instr one cycle, back to FETCH, instret unchanged.
- mem_ready held low in FETCH 15 cycles -> HALT, halted=1. Ready on 15th cycle -> DECODE instead. rst low -> FETCH, halted=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencing controller: walks each instruction through fetch/decode/execute/
// memory/writeback, drives datapath selects, watchdogs the memory handshake and counts retirements.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_instr,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

    logic [3:0]       r_state, w_next;
    logic [7:0]       r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_instret;
    logic             w_wait_state, w_timeout, w_retire, w_f3_ok;
    logic [2:0]       w_funct_alu;
    logic             w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal, w_halted;
    logic [1:0]       w_result_src, w_src_a, w_src_b;
    logic [2:0]       w_alu_ctrl;
    logic             w_unused;

    assign w_unused     = ^{funct7[6], funct7[4:0]};
    assign w_f3_ok      = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                          (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == WAIT_LIMIT);
    assign w_retire     = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                          ((r_state == S_MEMWRITE) && mem_ready);

    // ALU operation for register and immediate arithmetic
    always_comb begin
        w_funct_alu = 3'b000;
        case (funct3)
            3'b000:  w_funct_alu = ((Op == OP_R) && funct7[5]) ? 3'b001 : 3'b000;
            3'b010:  w_funct_alu = 3'b101;
            3'b110:  w_funct_alu = 3'b011;
            3'b111:  w_funct_alu = 3'b010;
            default: w_funct_alu = 3'b000;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Next-state selection; a handshake timeout overrides every wait state
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_HALT;
        end else begin
            case (r_state)
                S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_R:         w_next = w_f3_ok ? S_EXECR : S_TRAP;
                        OP_I:         w_next = w_f3_ok ? S_EXECI : S_TRAP;
                        OP_BR:        w_next = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                        OP_JAL:       w_next = S_JAL;
                        default:      w_next = S_TRAP;
                    endcase
                end
                S_MEMADR:   w_next = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
                S_EXECR:    w_next = S_ALUWB;
                S_EXECI:    w_next = S_ALUWB;
                S_JAL:      w_next = S_ALUWB;
                S_MEMWB:    w_next = S_FETCH;
                S_ALUWB:    w_next = S_FETCH;
                S_BEQ:      w_next = S_FETCH;
                S_TRAP:     w_next = S_FETCH;
                S_HALT:     w_next = S_HALT;
                default:    w_next = S_FETCH;
            endcase
        end
    end

    // Wait counter restarts on every state change and counts low-ready cycles
    always_comb begin
        if (w_next != r_state) begin
            w_wait_nxt = 8'd0;
        end else if (w_wait_state && !mem_ready) begin
            w_wait_nxt = r_wait_cnt + 8'd1;
        end else begin
            w_wait_nxt = r_wait_cnt;
        end
    end

    // State, watchdog and retirement counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_instret  <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end else begin
                r_instret <= r_instret;
            end
        end
    end

    // Per-state datapath controls
    always_comb begin
        w_pcwrite = 1'b0; w_adrsrc = 1'b0; w_memwrite = 1'b0; w_irwrite = 1'b0;
        w_regwrite = 1'b0; w_illegal = 1'b0; w_halted = 1'b0;
        w_result_src = 2'b00; w_src_a = 2'b00; w_src_b = 2'b00; w_alu_ctrl = 3'b000;
        case (r_state)
            S_FETCH: begin
                w_src_b = 2'b10; w_result_src = 2'b10;
                w_irwrite = mem_ready; w_pcwrite = mem_ready;
            end
            S_DECODE:   begin w_src_a = 2'b01; w_src_b = 2'b01; end
            S_MEMADR:   begin w_src_a = 2'b10; w_src_b = 2'b01; end
            S_MEMREAD:  w_adrsrc = 1'b1;
            S_MEMWB:    begin w_result_src = 2'b01; w_regwrite = 1'b1; end
            S_MEMWRITE: begin w_adrsrc = 1'b1; w_memwrite = 1'b1; end
            S_EXECR:    begin w_src_a = 2'b10; w_src_b = 2'b00; w_alu_ctrl = w_funct_alu; end
            S_EXECI:    begin w_src_a = 2'b10; w_src_b = 2'b01; w_alu_ctrl = w_funct_alu; end
            S_ALUWB:    w_regwrite = 1'b1;
            S_BEQ:      begin w_src_a = 2'b10; w_alu_ctrl = 3'b001; w_pcwrite = Zero; end
            S_JAL:      begin w_src_a = 2'b01; w_src_b = 2'b10; w_pcwrite = 1'b1; end
            S_TRAP:     w_illegal = 1'b1;
            S_HALT:     w_halted = 1'b1;
            default:    w_halted = 1'b0;
        endcase
    end

    // Strobes and status are held off for as long as reset is asserted
    assign PCWrite       = rst & w_pcwrite;
    assign AdrSrc        = w_adrsrc;
    assign MemWrite      = rst & w_memwrite;
    assign IRWrite       = rst & w_irwrite;
    assign RegWrite      = rst & w_regwrite;
    assign ResultSrc     = w_result_src;
    assign ALUSrcA       = w_src_a;
    assign ALUSrcB       = w_src_b;
    assign ALUControl    = w_alu_ctrl;
    assign illegal_instr = rst & w_illegal;
    assign halted        = rst & w_halted;
    assign retire        = rst & w_retire;
    assign instret       = r_instret;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm: per-cycle input records with hand-computed
// control words, plus hand-written watchdog, halt and reset sequences.
module tb_multicycle_control_fsm;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        zero;
        logic        mr;
        logic [18:0] exp;
        logic [31:0] cnt;
    } vec_t;

    logic        clk, rst_n;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        zero, mr;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
    logic        illegal_instr, halted, retire;
    logic [31:0] instret;
    logic [18:0] ctrl;
    int          n_total = 0;
    int          n_pass  = 0;
    vec_t        vecs[$];

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst_n), .Op(op), .funct3(f3), .funct7(f7), .Zero(zero), .mem_ready(mr),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal_instr(illegal_instr),
        .halted(halted), .retire(retire), .instret(instret)
    );

    // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal,halted,retire}
    assign ctrl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, illegal_instr, halted, retire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [18:0] ex(input logic [4:0] en, input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] imm,
                                       input logic [2:0] fl);
        return {en, rs, sa, sb, alu, imm, fl};
    endfunction

    function automatic vec_t mkv(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b,
                                 input logic z, input logic m, input logic [18:0] e, input logic [31:0] c);
        vec_t v;
        v.op = o; v.f3 = a; v.f7 = b; v.zero = z; v.mr = m; v.exp = e; v.cnt = c;
        return v;
    endfunction

    task automatic p(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b, input logic z,
                     input logic m, input logic [18:0] e, input logic [31:0] c);
        vecs.push_back(mkv(o, a, b, z, m, e, c));
    endtask

    // FETCH (ready) followed by DECODE for one instruction
    task automatic fd(input logic [6:0] o, input logic [2:0] a, input logic [6:0] b, input logic z,
                      input logic [1:0] imm, input logic [31:0] c);
        p(o, a, b, z, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, imm, 3'b000), c);
        p(o, a, b, z, 1'b1, ex(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, imm, 3'b000), c);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Apply one cycle of inputs, compare mid-cycle, then advance past the next rising edge
    task automatic run(input vec_t v, input string nm);
        op = v.op; f3 = v.f3; f7 = v.f7; zero = v.zero; mr = v.mr;
        #3;
        check({nm, " ctrl"}, {13'd0, ctrl}, {13'd0, v.exp});
        check({nm, " instret"}, instret, v.cnt);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; op = OP_R; f3 = 3'b000; f7 = 7'd0; zero = 1'b0; mr = 1'b1;
        #3;
        check("reset ctrl", {13'd0, ctrl}, {13'd0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000)});
        check("reset instret", instret, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // add, sub, addi(f7 set), slti, and, ori
        fd(OP_R, 3'b000, 7'b0000000, 1'b0, 2'b00, 32'd0);
        p(OP_R, 3'b000, 7'b0000000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000), 32'd0);
        p(OP_R, 3'b000, 7'b0000000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd0);
        fd(OP_R, 3'b000, 7'b0100000, 1'b0, 2'b00, 32'd1);
        p(OP_R, 3'b000, 7'b0100000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000), 32'd1);
        p(OP_R, 3'b000, 7'b0100000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd1);
        fd(OP_I, 3'b000, 7'b0100000, 1'b0, 2'b00, 32'd2);
        p(OP_I, 3'b000, 7'b0100000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000), 32'd2);
        p(OP_I, 3'b000, 7'b0100000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd2);
        fd(OP_I, 3'b010, 7'b0000000, 1'b0, 2'b00, 32'd3);
        p(OP_I, 3'b010, 7'b0000000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b101, 2'b00, 3'b000), 32'd3);
        p(OP_I, 3'b010, 7'b0000000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd3);
        fd(OP_R, 3'b111, 7'b0000000, 1'b0, 2'b00, 32'd4);
        p(OP_R, 3'b111, 7'b0000000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 3'b000), 32'd4);
        p(OP_R, 3'b111, 7'b0000000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd4);
        fd(OP_I, 3'b110, 7'b0000000, 1'b0, 2'b00, 32'd5);
        p(OP_I, 3'b110, 7'b0000000, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00, 3'b000), 32'd5);
        p(OP_I, 3'b110, 7'b0000000, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd5);
        // lw with three not-ready cycles in MEMREAD: 8 cycles total
        fd(OP_LW, 3'b010, 7'd0, 1'b0, 2'b00, 32'd6);
        p(OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000), 32'd6);
        for (int k = 0; k < 3; k++)
            p(OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, ex(5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000), 32'd6);
        p(OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000), 32'd6);
        p(OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd6);
        // sw: MemWrite held four cycles, retires once
        fd(OP_SW, 3'b010, 7'd0, 1'b0, 2'b01, 32'd7);
        p(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 3'b000), 32'd7);
        for (int k = 0; k < 3; k++)
            p(OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, ex(5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000), 32'd7);
        p(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b001), 32'd7);
        // beq taken / not taken
        fd(OP_BR, 3'b000, 7'd0, 1'b1, 2'b10, 32'd8);
        p(OP_BR, 3'b000, 7'd0, 1'b1, 1'b1, ex(5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 3'b001), 32'd8);
        fd(OP_BR, 3'b000, 7'd0, 1'b0, 2'b10, 32'd9);
        p(OP_BR, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 3'b001), 32'd9);
        // jal
        fd(OP_JAL, 3'b000, 7'd0, 1'b0, 2'b11, 32'd10);
        p(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 3'b000), 32'd10);
        p(OP_JAL, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 3'b001), 32'd10);
        // traps: unknown opcode, R-type funct3 001, beq funct3 001; none retire
        fd(OP_BAD, 3'b000, 7'd0, 1'b0, 2'b00, 32'd11);
        p(OP_BAD, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b100), 32'd11);
        fd(OP_R, 3'b001, 7'd0, 1'b0, 2'b00, 32'd11);
        p(OP_R, 3'b001, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b100), 32'd11);
        fd(OP_BR, 3'b001, 7'd0, 1'b0, 2'b10, 32'd11);
        p(OP_BR, 3'b001, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10, 3'b100), 32'd11);
        p(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000), 32'd11);

        for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

        // Reset from DECODE: strobes forced low while rst is low
        rst_n = 1'b0; op = OP_R; f3 = 3'b000; f7 = 7'd0; mr = 1'b1;
        #3;
        check("rst2 ctrl", {13'd0, ctrl}, {13'd0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000)});
        check("rst2 instret", instret, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Ready arriving on the 15th low-limit cycle still proceeds
        for (int k = 0; k < 14; k++)
            run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000), 32'd0), "wd_low");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000), 32'd0), "wd_ready15");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), 32'd0), "wd_decode");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000), 32'd0), "wd_execr");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd0), "wd_aluwb");
        // Fifteen consecutive low cycles in FETCH lead to HALT, which is absorbing
        for (int k = 0; k < 15; k++)
            run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000), 32'd1), "halt_low");
        for (int k = 0; k < 3; k++)
            run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010), 32'd1), "halt_hold");
        rst_n = 1'b0;
        #3;
        check("halt_rst ctrl", {13'd0, ctrl}, {13'd0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000)});
        check("halt_rst instret", instret, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset in the middle of a store drops MemWrite immediately and clears instret
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 3'b000), 32'd0), "mid_fetch");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 3'b000), 32'd0), "mid_decode");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 3'b000), 32'd0), "mid_execr");
        run(mkv(OP_R, 3'b000, 7'd0, 1'b0, 1'b1, ex(5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001), 32'd0), "mid_aluwb");
        run(mkv(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000), 32'd1), "mid_sw_fetch");
        run(mkv(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b01, 3'b000), 32'd1), "mid_sw_decode");
        run(mkv(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 3'b000), 32'd1), "mid_sw_memadr");
        for (int k = 0; k < 2; k++)
            run(mkv(OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, ex(5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000), 32'd1), "mid_sw_memwrite");
        rst_n = 1'b0;
        #3;
        check("mid_rst ctrl", {13'd0, ctrl}, {13'd0, ex(5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000)});
        check("mid_rst instret", instret, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(mkv(OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, ex(5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 3'b000), 32'd0), "post_rst_fetch");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
